// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered multi-cycle results,
// with a starvation limiter and halt drain. Optional stall counter behind WB_PERF_CNT_EN.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pl_wen,
  input  logic [4:0]  pl_rw,
  input  logic [31:0] pl_di,
  input  logic        pl_halt,
  output logic        pl_stall,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rw,
  input  logic [31:0] mc_di,
  output logic        mc_ready,
  output logic        WEN_out,
  output logic [4:0]  Rw_out,
  output logic [31:0] Di_out,
  output logic        halted
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } halt_state_e;

  logic [4:0]    rw_mem [DEPTH];
  logic [31:0]   di_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  halt_state_e   state_q, state_d;
  logic          wen_q, wen_d;
  logic [4:0]    rw_q, rw_d;
  logic [31:0]   di_q, di_d;

  logic          fifo_empty;
  logic          halt_seen;
  logic          push;
  logic          pop;
  logic          pl_elig;
  logic          grant_pl;
  logic          grant_head;

  assign fifo_empty = (count_q == '0);
  assign halt_seen  = (state_q != ST_RUN);
  assign mc_ready   = (count_q != CW'(DEPTH));
  assign pl_stall   = (starve_q == SW'(STARVE_LIMIT));

  // Register 0 results complete the handshake but never occupy a slot.
  assign push = mc_valid && mc_ready && (mc_rw != 5'd0);

  assign pl_elig    = pl_wen && (pl_rw != 5'd0) && !pl_halt && !halt_seen && !pl_stall;
  assign grant_pl   = pl_elig;
  assign grant_head = !fifo_empty && (pl_stall || !pl_elig);
  assign pop        = grant_head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_head) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Output register: Rw/Di hold their last value when nothing is granted.
  always_comb begin
    wen_d = 1'b0;
    rw_d  = rw_q;
    di_d  = di_q;
    if (grant_pl) begin
      wen_d = 1'b1;
      rw_d  = pl_rw;
      di_d  = pl_di;
    end else if (grant_head) begin
      wen_d = 1'b1;
      rw_d  = rw_mem[rd_ptr_q];
      di_d  = di_mem[rd_ptr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (pl_halt && !pl_stall) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !mc_valid) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      rw_mem[wr_ptr_q] <= mc_rw;
      di_mem[wr_ptr_q] <= mc_di;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      state_q  <= ST_RUN;
      wen_q    <= 1'b0;
      rw_q     <= '0;
      di_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      state_q  <= state_d;
      wen_q    <= wen_d;
      rw_q     <= rw_d;
      di_q     <= di_d;
    end
  end

  assign WEN_out = wen_q;
  assign Rw_out  = rw_q;
  assign Di_out  = di_q;
  assign halted  = (state_q == ST_HALTED);

`ifdef WB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (pl_stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
